// File: rtl/bitcoin_share_checker.sv
// Share checker: expands compact nBits to a 256-bit target, tests SHA256d digests against it
// and queues winning nonces for the host. Optional counters under BTC_CHK_STATS_EN.
module bitcoin_share_checker #(
  parameter int unsigned FIFO_DEPTH = 4
`ifdef BTC_CHK_STATS_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bits_load,
  input  logic [31:0]     bits_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_nonce,
  input  logic [7:0][31:0] in_digest,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_nonce,
  output logic [63:0]     out_hash_hi,
  output logic            tgt_valid,
  output logic            cfg_err
`ifdef BTC_CHK_STATS_EN
  , output logic [CNT_W-1:0] stat_checked,
  output logic [CNT_W-1:0] stat_hits
`endif
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  typedef enum logic [1:0] {ST_NO_TGT, ST_LOAD, ST_RUN, ST_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_bits_pend;
  logic [255:0]    r_target;
  logic            r_tgt_valid, r_cfg_err;

  logic            r_s1_valid;
  logic [31:0]     r_s1_nonce;
  logic [63:0]     r_s1_hash_hi;
  logic [7:0]      r_s1_lt, r_s1_eq;

  logic [31:0]     r_fifo_nonce [FIFO_DEPTH];
  logic [63:0]     r_fifo_hash  [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_FW-1:0] r_count;

  logic [7:0]      w_exp;
  logic [23:0]     w_man;
  logic            w_malformed;
  logic [255:0]    w_target_exp;
  logic [7:0][31:0] w_hash;
  logic [7:0]      w_lt, w_eq;
  logic            w_s2_hit, w_decided;
  logic            w_accept, w_push, w_pop;

  // Compact nBits expansion from the pending register; malformed values give an empty target
  always_comb begin
    w_exp        = r_bits_pend[31:24];
    w_man        = r_bits_pend[23:0];
    w_malformed  = (w_exp > 8'd32) || w_man[23];
    w_target_exp = '0;
    if (!w_malformed) begin
      if (w_exp <= 8'd3)
        w_target_exp = 256'(w_man) >> ((32'd3 - 32'(w_exp)) * 32'd8);
      else
        w_target_exp = 256'(w_man) << ((32'(w_exp) - 32'd3) * 32'd8);
    end
  end

  // Byte-swap each digest word into hash-value order and compare word-wise with the target
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_hash[i] = {in_digest[i][7:0], in_digest[i][15:8], in_digest[i][23:16], in_digest[i][31:24]};
      w_lt[i]   = w_hash[i] <  r_target[32*i +: 32];
      w_eq[i]   = w_hash[i] == r_target[32*i +: 32];
    end
  end

  // Most significant unequal word decides; all-equal counts as a hit
  always_comb begin
    w_s2_hit  = 1'b1;
    w_decided = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!w_decided && !r_s1_eq[i]) begin
        w_s2_hit  = r_s1_lt[i];
        w_decided = 1'b1;
      end
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_push   = r_s1_valid && w_s2_hit;
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_NO_TGT;
    else     r_state <= w_state_nxt;
  end

  // Next state and credit-based accept
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_NO_TGT: if (bits_load) w_state_nxt = ST_LOAD;
      ST_LOAD:   if (!bits_load) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bits_load) w_state_nxt = ST_DRAIN;
        in_ready = !bits_load && ((r_count + CNT_FW'(r_s1_valid)) < CNT_FW'(FIFO_DEPTH));
      end
      ST_DRAIN:  if (!r_s1_valid) w_state_nxt = ST_LOAD;
      default:   w_state_nxt = ST_NO_TGT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bits_pend  <= '0;
      r_target     <= '0;
      r_tgt_valid  <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_nonce   <= '0;
      r_s1_hash_hi <= '0;
      r_s1_lt      <= '0;
      r_s1_eq      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_nonce[i] <= '0;
        r_fifo_hash[i]  <= '0;
      end
    end else begin
      if (bits_load) r_bits_pend <= bits_in;
      r_cfg_err <= 1'b0;
      if (r_state == ST_LOAD) begin
        r_target    <= w_target_exp;
        r_cfg_err   <= w_malformed;
        r_tgt_valid <= 1'b1;
      end
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_nonce   <= in_nonce;
        r_s1_hash_hi <= {w_hash[7], w_hash[6]};
        r_s1_lt      <= w_lt;
        r_s1_eq      <= w_eq;
      end
      if (w_push) begin
        r_fifo_nonce[r_wr_ptr] <= r_s1_nonce;
        r_fifo_hash[r_wr_ptr]  <= r_s1_hash_hi;
        r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_FW'(1);
        2'b01:   r_count <= r_count - CNT_FW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid   = (r_count != '0);
  assign out_nonce   = r_fifo_nonce[r_rd_ptr];
  assign out_hash_hi = r_fifo_hash[r_rd_ptr];
  assign tgt_valid   = r_tgt_valid;
  assign cfg_err     = r_cfg_err;

`ifdef BTC_CHK_STATS_EN
  logic [CNT_W-1:0] r_stat_checked, r_stat_hits;

  // Saturating counters, restarted with every new target
  always_ff @(posedge clk) begin
    if (rst || bits_load) begin
      r_stat_checked <= '0;
      r_stat_hits    <= '0;
    end else begin
      if (w_accept && (r_stat_checked != '1)) r_stat_checked <= r_stat_checked + CNT_W'(1);
      if (w_push && (r_stat_hits != '1))      r_stat_hits    <= r_stat_hits + CNT_W'(1);
    end
  end

  assign stat_checked = r_stat_checked;
  assign stat_hits    = r_stat_hits;
`endif

endmodule

// File: tb/tb_bitcoin_share_checker.sv
// Directed + randomized bench for bitcoin_share_checker against an arithmetic reference model
// (target by multiply/divide, hit by 256-bit compare, results in a timed expectation queue).
module tb_bitcoin_share_checker;

  logic             clk = 1'b0;
  logic             rst;
  logic             bits_load;
  logic [31:0]      bits_in;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_nonce;
  logic [7:0][31:0] in_digest;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_nonce;
  logic [63:0]      out_hash_hi;
  logic             tgt_valid;
  logic             cfg_err;

  always #5 clk = ~clk;

  bitcoin_share_checker #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bits_load(bits_load), .bits_in(bits_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_nonce(in_nonce), .in_digest(in_digest),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
    .out_hash_hi(out_hash_hi), .tgt_valid(tgt_valid), .cfg_err(cfg_err)
  );

  typedef struct {
    logic [31:0] nonce;
    logic [63:0] hi;
    int          rdy;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           cfg_err_cnt = 0;
  logic [255:0] model_t = '0;
  logic         model_loaded = 1'b0;
  logic         smp_rdy;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Hash value <-> digest: reverse bytes within each 32-bit word (its own inverse)
  function automatic logic [255:0] hash_of(input logic [255:0] d);
    logic [255:0] h;
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++)
        h[32*w + 8*b +: 8] = d[32*w + 8*(3-b) +: 8];
    return h;
  endfunction

  // {err, target}: mantissa scaled by powers of 256
  function automatic logic [256:0] expand(input logic [31:0] b);
    int           e;
    logic [255:0] m, p;
    e = int'(b[31:24]);
    m = 256'(b[23:0]);
    p = 256'd1;
    if (e > 32 || b[23]) return {1'b1, 256'd0};
    for (int k = 0; k < ((e >= 3) ? e - 3 : 3 - e); k++) p = p * 256'd256;
    if (e >= 3) return {1'b0, m * p};
    return {1'b0, m / p};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive, sample away from the edge, check, update the model
  task automatic cycle(input logic v, input logic [31:0] n, input logic [255:0] h,
                       input logic ld, input logic [31:0] b, input logic ordy,
                       input logic ck_rdy, output logic acc);
    logic [256:0] ex;
    logic         mv;
    in_valid  = v;
    in_nonce  = n;
    in_digest = hash_of(h);
    bits_load = ld;
    bits_in   = b;
    out_ready = ordy;
    #1;
    smp_rdy = in_ready;
    acc = in_valid && in_ready;
    if (cfg_err === 1'b1) cfg_err_cnt++;
    if (!rst) begin
      mv = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("out_valid", out_valid, mv);
      if (mv) begin
        chk("out_nonce", out_nonce, q[0].nonce);
        chk("out_hash_hi", out_hash_hi, q[0].hi);
      end
      if (ck_rdy) chk("in_ready_credit", in_ready, (!ld && q.size() < 4));
      if (!model_loaded) chk("in_ready_no_tgt", in_ready, 1'b0);
      if (mv && ordy) void'(q.pop_front());
    end
    if (acc && (h <= model_t)) q.push_back('{nonce: n, hi: h[255:192], rdy: cyc + 2});
    if (ld) begin
      ex = expand(b);
      model_t = ex[255:0];
      model_loaded = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, ordy, 1'b0, acc);
  endtask

  task automatic do_load(input logic [31:0] b, input logic ordy, input int exp_err);
    logic acc;
    cfg_err_cnt = 0;
    cycle(1'b0, '0, '0, 1'b1, b, ordy, 1'b0, acc);
    idle(5, ordy);
    chk("cfg_err_pulses", cfg_err_cnt, exp_err);
    chk("tgt_valid_loaded", tgt_valid, 1'b1);
  endtask

  task automatic send(input logic [31:0] n, input logic [255:0] h, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, n, h, 1'b0, '0, ordy, 1'b0, acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    bits_load = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    q.delete();
    model_loaded = 1'b0;
    model_t = '0;
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_nonce", out_nonce, 32'd0);
    chk("rst_out_hash_hi", out_hash_hi, 64'd0);
    chk("rst_tgt_valid", tgt_valid, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic         acc;
    logic         saw_stall;
    logic         ld_again;
    logic [255:0] vec_h;
    logic [255:0] hs [8];
    logic [255:0] hh;
    logic [31:0]  nn;
    logic [31:0]  rb;
    int           sent;

    rst = 1'b1;
    bits_load = 1'b0;
    bits_in = '0;
    in_valid = 1'b0;
    in_nonce = '0;
    in_digest = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_reset_state();

    // Known-good share against nBits 19015f53
    vec_h = hash_of(256'h00000000_00000000_78a467e0_fedd4a02_2836c9cd_2da58a97_42bdfa91_502a9892);
    do_load(32'h19015f53, 1'b1, 0);
    cycle(1'b1, 32'h33087548, vec_h, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("t1_accept", acc, 1'b1);
    idle(4, 1'b1);

    // Harder target: same digest misses
    do_load(32'h1800ffff, 1'b1, 0);
    send(32'h33087548, vec_h, 1'b1);
    idle(4, 1'b1);

    // Malformed targets: exponent too large, negative mantissa
    do_load(32'h2100ffff, 1'b1, 1);
    send($urandom, rand256(), 1'b1);
    send($urandom, rand256() >> 200, 1'b1);
    idle(3, 1'b1);
    do_load(32'h1d80ffff, 1'b1, 1);
    send($urandom, rand256() >> 100, 1'b1);
    idle(3, 1'b1);

    // Small exponent: equality boundary
    do_load(32'h03123456, 1'b1, 0);
    send(32'h0000aaaa, 256'h123456, 1'b1);
    send(32'h0000bbbb, 256'h123457, 1'b1);
    idle(4, 1'b1);

    // Backpressure: 8 hits with the host stalled for a while
    do_load(32'h2000ffff, 1'b0, 0);
    for (int i = 0; i < 8; i++) hs[i] = rand256() >> 20;
    sent = 0;
    saw_stall = 1'b0;
    for (int t = 0; t < 60 && (sent < 8 || q.size() > 0); t++) begin
      cycle(sent < 8, 32'hA000_0000 + 32'(sent), hs[sent % 8], 1'b0, '0, t >= 12, 1'b1, acc);
      if (sent < 8 && !smp_rdy) saw_stall = 1'b1;
      if (acc) sent++;
    end
    chk("t4_sent", sent, 8);
    chk("t4_stall_seen", saw_stall, 1'b1);
    chk("t4_all_popped", q.size(), 0);

    // Random stream with target reloads mid-flight
    nn = $urandom;
    hh = rand256();
    ld_again = 1'b0;
    for (int t = 0; t < 800; t++) begin
      logic ld;
      ld = ld_again || ($urandom_range(0, 39) == 0);
      ld_again = ld && !ld_again && ($urandom_range(0, 1) == 0);
      rb = {8'($urandom_range(0, 34)), 24'($urandom)};
      if ($urandom_range(0, 7) != 0) rb[23] = 1'b0;
      cycle($urandom_range(0, 3) != 0, nn, hh, ld, rb, $urandom_range(0, 9) < 7, 1'b0, acc);
      if (acc) begin
        nn = $urandom;
        case ($urandom_range(0, 4))
          0:       hh = model_t;
          1:       hh = model_t + 256'd1;
          2:       hh = model_t - 256'd1;
          3:       hh = rand256() >> $urandom_range(0, 255);
          default: hh = rand256();
        endcase
      end
    end
    idle(12, 1'b1);
    chk("rand_drained", q.size(), 0);

    // Reset while results are queued and a pair is in flight
    do_load(32'h207fffff, 1'b0, 0);
    send(32'h11110001, rand256() >> 16, 1'b0);
    send(32'h11110002, rand256() >> 16, 1'b0);
    send(32'h11110003, rand256() >> 16, 1'b0);
    do_reset();
    check_reset_state();
    idle(3, 1'b1);
    do_load(32'h207fffff, 1'b1, 0);
    send(32'h22220001, rand256() >> 16, 1'b1);
    idle(4, 1'b1);
    chk("post_rst_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
